// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite widths, response codes and the master FSM state type.
package axi4lite_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4lite_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, clears on synchronous reset.
module axi4lite_sat_counter #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator, one outstanding transaction. Define AXI4LITE_MASTER_STATS_EN to add
// saturating write/read/error counters.
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_WIDTH,
    parameter int DATA_W = AXI_DATA_WIDTH,
    parameter int STAT_W = 16
) (
    input  logic              A_CLK,
    input  logic              A_RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              AW_VALID,
    input  logic              AW_READY,
    output logic [ADDR_W-1:0] AW_ADDR,
    output logic              W_VALID,
    input  logic              W_READY,
    output logic [DATA_W-1:0] W_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [1:0]        B_RESP,
    output logic              AR_VALID,
    input  logic              AR_READY,
    output logic [ADDR_W-1:0] AR_ADDR,
    input  logic              R_VALID,
    output logic              R_READY,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic [1:0]        R_RESP
`ifdef AXI4LITE_MASTER_STATS_EN
    ,
    output logic [STAT_W-1:0] wr_count,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] err_count
`endif
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic              aw_valid_q, aw_valid_d;
    logic              w_valid_q, w_valid_d;
    logic              ar_valid_q, ar_valid_d;
    logic              is_wr_q, is_wr_d;
    logic              wr_capt, rd_capt, rsp_done;

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            resp_q     <= RESP_OKAY;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            is_wr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            is_wr_q    <= is_wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        is_wr_d    = is_wr_q;
        wr_capt    = 1'b0;
        rd_capt    = 1'b0;
        rsp_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    is_wr_d = cmd_write;
                    if (cmd_write) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_ADDR;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; each VALID drops on its own handshake
                if (aw_valid_q && AW_READY) aw_valid_d = 1'b0;
                if (w_valid_q && W_READY)   w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (B_VALID) begin
                    resp_d  = B_RESP;
                    rdata_d = '0;
                    wr_capt = 1'b1;
                    state_d = RSP;
                end
            end
            RD_ADDR: begin
                if (AR_READY) begin
                    ar_valid_d = 1'b0;
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (R_VALID) begin
                    rdata_d = R_DATA;
                    resp_d  = R_RESP;
                    rd_capt = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is a flop or a decode of state_q, so AXI inputs never reach AXI outputs
    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign B_READY   = (state_q == WR_RESP);
    assign R_READY   = (state_q == RD_DATA);
    assign AW_VALID  = aw_valid_q;
    assign W_VALID   = w_valid_q;
    assign AR_VALID  = ar_valid_q;
    assign AW_ADDR   = addr_q;
    assign AR_ADDR   = addr_q;
    assign W_DATA    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

`ifdef AXI4LITE_MASTER_STATS_EN
    logic wr_inc, rd_inc, err_inc;

    assign wr_inc  = rsp_done && is_wr_q;
    assign rd_inc  = rsp_done && !is_wr_q;
    assign err_inc = (wr_capt && resp_is_err(B_RESP)) || (rd_capt && resp_is_err(R_RESP));

    axi4lite_sat_counter #(.STAT_W(STAT_W)) u_wr_cnt (
        .clk(A_CLK), .rst(A_RST), .inc(wr_inc), .count(wr_count)
    );
    axi4lite_sat_counter #(.STAT_W(STAT_W)) u_rd_cnt (
        .clk(A_CLK), .rst(A_RST), .inc(rd_inc), .count(rd_count)
    );
    axi4lite_sat_counter #(.STAT_W(STAT_W)) u_err_cnt (
        .clk(A_CLK), .rst(A_RST), .inc(err_inc), .count(err_count)
    );
`else
    logic stats_unused;
    assign stats_unused = ^{(STAT_W > 0), wr_capt, rd_capt, rsp_done, is_wr_q};
`endif

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master with a cycle-stepped slave and memory model.
module tb_axi4lite_master;

    logic        A_CLK = 1'b0;
    logic        A_RST;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
    logic        AR_VALID, AR_READY, R_VALID, R_READY;
    logic [31:0] AW_ADDR, W_DATA, AR_ADDR, R_DATA;
    logic [1:0]  B_RESP, R_RESP;
`ifdef AXI4LITE_MASTER_STATS_EN
    logic [15:0] wr_count, rd_count, err_count;
`endif

    axi4lite_master #(.ADDR_W(32), .DATA_W(32), .STAT_W(16)) dut (
        .A_CLK(A_CLK), .A_RST(A_RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
`ifdef AXI4LITE_MASTER_STATS_EN
        , .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
`endif
    );

    always #5 A_CLK = ~A_CLK;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] mem [16];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge A_CLK);
        #1;
    endtask

    task automatic idle_bus;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        AW_READY = 1'b0; W_READY = 1'b0; AR_READY = 1'b0;
        B_VALID = 1'b0; B_RESP = 2'b00; R_VALID = 1'b0; R_DATA = '0; R_RESP = 2'b00;
    endtask

    // One full command/response exchange. Cycle k=0 presents the command; a_dly/w_dly hold off
    // the address/data READY for that many cycles after VALID rises; hold keeps rsp_ready low
    // for that many cycles once rsp_valid appears. Protocol breaches accumulate in viol.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int a_dly, input int w_dly, input logic [1:0] sresp, input int hold,
                       output logic [31:0] rdata, output logic [1:0] resp,
                       output int lat, output int nacc, output int viol);
        bit aw_done = 0, w_done = 0, ar_done = 0, got = 0;
        int first = -1;
        rdata = '0; resp = '0; lat = -1; nacc = 0; viol = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        rsp_ready = (hold == 0);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge A_CLK);
            if (k == 0 && !cmd_ready) viol++;
            if (k > 0 && cmd_ready) viol++;
            if (wr) begin
                if (aw_done && AW_VALID) viol++;
                if (w_done && W_VALID) viol++;
                if (k >= 1 && !aw_done && !AW_VALID) viol++;
                if (k >= 1 && !w_done && !W_VALID) viol++;
                if (AW_VALID && AW_ADDR !== addr) viol++;
                if (W_VALID && W_DATA !== wdata) viol++;
                if (AR_VALID) viol++;
                if (AW_VALID && AW_READY) aw_done = 1;
                if (W_VALID && W_READY) w_done = 1;
                if (B_VALID && B_READY) nacc++;
            end else begin
                if (ar_done && AR_VALID) viol++;
                if (k >= 1 && !ar_done && !AR_VALID) viol++;
                if (AR_VALID && AR_ADDR !== addr) viol++;
                if (AW_VALID || W_VALID) viol++;
                if (AR_VALID && AR_READY) ar_done = 1;
                if (R_VALID && R_READY) nacc++;
            end
            if (rsp_valid) begin
                if (first < 0) begin
                    first = k; lat = k; rdata = rsp_rdata; resp = rsp_resp;
                end else if (rsp_rdata !== rdata || rsp_resp !== resp) begin
                    viol++;
                end
                if (rsp_ready) got = 1;
            end
            @(posedge A_CLK);
            #1;
            cmd_valid = 1'b0;
            if (wr && aw_done && w_done) mem[addr[5:2]] = wdata;
            AW_READY  = wr && !aw_done && (k + 1 >= 1 + a_dly);
            W_READY   = wr && !w_done && (k + 1 >= 1 + w_dly);
            AR_READY  = !wr && !ar_done && (k + 1 >= 1 + a_dly);
            B_VALID   = wr && aw_done && w_done && (nacc == 0);
            B_RESP    = sresp;
            R_VALID   = !wr && ar_done && (nacc == 0);
            R_DATA    = mem[addr[5:2]];
            R_RESP    = sresp;
            rsp_ready = (first >= 0) ? (k + 1 >= first + hold) : (hold == 0);
        end
        if (!got) chk("txn_timeout", 32'(got), 32'(1));
        idle_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          lat, nacc, viol;

        idle_bus();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        A_RST = 1'b1;
        tick();
        tick();
        @(negedge A_CLK);
        chk("rst_valids", 32'({AW_VALID, W_VALID, AR_VALID, B_READY, R_READY, rsp_valid}), 32'(0));
        chk("rst_addr_data", AW_ADDR | AR_ADDR | W_DATA | rsp_rdata, 32'(0));
        chk("rst_resp", 32'(rsp_resp), 32'(0));
        @(posedge A_CLK);
        #1;
        A_RST = 1'b0;
        @(negedge A_CLK);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));
        tick();

        // Always-ready write
        txn(1'b1, 32'h4, 32'hDEADBEEF, 0, 0, 2'b00, 0, rd, rs, lat, nacc, viol);
        chk("wr_lat", 32'(lat), 32'(3));
        chk("wr_rdata", rd, 32'h0);
        chk("wr_resp", 32'(rs), 32'(0));
        chk("wr_b_accepts", 32'(nacc), 32'(1));
        chk("wr_protocol", 32'(viol), 32'(0));
        tick();

        // W accepted two cycles before AW
        txn(1'b1, 32'h10, 32'hA5A50001, 2, 0, 2'b00, 0, rd, rs, lat, nacc, viol);
        chk("skew_w_first_lat", 32'(lat), 32'(5));
        chk("skew_w_first_b", 32'(nacc), 32'(1));
        chk("skew_w_first_protocol", 32'(viol), 32'(0));

        // AW accepted two cycles before W (back-to-back, no idle gap)
        txn(1'b1, 32'h14, 32'h5A5A0002, 0, 2, 2'b00, 0, rd, rs, lat, nacc, viol);
        chk("skew_aw_first_lat", 32'(lat), 32'(5));
        chk("skew_aw_first_b", 32'(nacc), 32'(1));
        chk("skew_aw_first_protocol", 32'(viol), 32'(0));

        // Write then read back through the memory model
        txn(1'b1, 32'h8, 32'h12345678, 0, 0, 2'b00, 0, rd, rs, lat, nacc, viol);
        chk("wr8_protocol", 32'(viol), 32'(0));
        txn(1'b0, 32'h8, 32'h0, 0, 0, 2'b00, 0, rd, rs, lat, nacc, viol);
        chk("rd8_data", rd, 32'h12345678);
        chk("rd8_lat", 32'(lat), 32'(3));
        chk("rd8_resp", 32'(rs), 32'(0));
        chk("rd8_protocol", 32'(viol), 32'(0));

        // Response held off for five cycles
        txn(1'b0, 32'h4, 32'h0, 1, 0, 2'b00, 5, rd, rs, lat, nacc, viol);
        chk("bp_data", rd, 32'hDEADBEEF);
        chk("bp_lat", 32'(lat), 32'(4));
        chk("bp_stable_protocol", 32'(viol), 32'(0));

        // Slave error on read
        txn(1'b0, 32'hC, 32'h0, 0, 0, 2'b10, 0, rd, rs, lat, nacc, viol);
        chk("slverr_resp", 32'(rs), 32'(2));
        chk("slverr_data", rd, 32'h0);
        chk("slverr_r_accepts", 32'(nacc), 32'(1));
`ifdef AXI4LITE_MASTER_STATS_EN
        @(negedge A_CLK);
        chk("stat_wr", 32'(wr_count), 32'(4));
        chk("stat_rd", 32'(rd_count), 32'(3));
        chk("stat_err", 32'(err_count), 32'(1));
`endif

        // Stray responses while idle must be ignored
        tick();
        B_VALID = 1'b1; B_RESP = 2'b10; R_VALID = 1'b1; R_RESP = 2'b11;
        @(negedge A_CLK);
        chk("stray_readies", 32'({B_READY, R_READY}), 32'(0));
        tick();
        @(negedge A_CLK);
        chk("stray_no_rsp", 32'({rsp_valid, cmd_ready}), 32'(1));
        idle_bus();
        tick();

        // Reset while AW/W are pending
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hCAFEF00D;
        tick();
        cmd_valid = 1'b0;
        @(negedge A_CLK);
        chk("midrst_pre_valids", 32'({AW_VALID, W_VALID}), 32'(3));
        tick();
        A_RST = 1'b1;
        tick();
        @(negedge A_CLK);
        chk("midrst_valids", 32'({AW_VALID, W_VALID, AR_VALID, rsp_valid}), 32'(0));
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
`ifdef AXI4LITE_MASTER_STATS_EN
        chk("midrst_stats", 32'(wr_count | rd_count | err_count), 32'(0));
`endif
        @(posedge A_CLK);
        #1;
        A_RST = 1'b0;
        B_VALID = 1'b1;
        tick();
        tick();
        @(negedge A_CLK);
        chk("midrst_no_rsp", 32'({rsp_valid, B_READY, cmd_ready}), 32'(1));
        idle_bus();
        tick();

        txn(1'b0, 32'h10, 32'h0, 0, 0, 2'b00, 0, rd, rs, lat, nacc, viol);
        chk("post_rst_rd_data", rd, 32'hA5A50001);
        chk("post_rst_rd_protocol", 32'(viol), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
